// File: rtl/lc3_pipe_controller_if.sv
// Handshake/control bundle between the LC-3 pipeline sequencer and the datapath.
// master: sequencer side (reads status/IR, drives enables); slave: datapath side.
interface lc3_pipe_controller_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic [1:0]  mem_state;
    logic        br_taken;

    modport master (
        input  complete_instr, complete_data, IR, IR_Exec, psr,
        output enable_updatePC, enable_fetch, enable_decode,
        output enable_execute, enable_writeback,
        output bypass_alu_1, bypass_alu_2, mem_state, br_taken
    );

    modport slave (
        output complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        input  enable_updatePC, enable_fetch, enable_decode,
        input  enable_execute, enable_writeback,
        input  bypass_alu_1, bypass_alu_2, mem_state, br_taken
    );
endinterface

// File: rtl/lc3_pipe_controller.sv
// LC-3 five-stage pipeline sequencer: stage enables, memory state, forwarding, branch.
// Ports: clock, reset (async, active-high), bus (lc3_pipe_controller_if.master).
module lc3_pipe_controller (
    input  logic                  clock,
    input  logic                  reset,
    lc3_pipe_controller_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_MEM_IND = 3'd2;
    localparam logic [2:0] S_MEM_ACC = 3'd3;
    localparam logic [2:0] S_BR_WAIT = 3'd4;
    localparam logic [2:0] S_BR_RES  = 3'd5;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    logic [2:0] state_q, state_d;
    logic [3:0] op_x, op_d;
    logic       x_mem, x_ind, x_load, x_alu, x_jmp;
    logic       d_alu, d_ctl, d_src1, d_src2;
    logic       fwd_1, fwd_2;

    always_comb begin
        op_x   = bus.IR_Exec[15:12];
        op_d   = bus.IR[15:12];
        // Loads/stores are exactly the opcodes with bit1 set outside 11xx.
        x_mem  = op_x[1] && (op_x[3:2] != 2'b11);
        x_ind  = (op_x[3:1] == 3'b101);
        x_load = x_mem && !op_x[0];
        x_alu  = (op_x == OP_ADD) || (op_x == OP_AND) || (op_x == OP_NOT);
        x_jmp  = (op_x == OP_JMP);
        d_alu  = (op_d == OP_ADD) || (op_d == OP_AND) ||
                 (op_d == OP_NOT) || (op_d == OP_LEA);
        d_ctl  = (op_d == OP_BR) || (op_d == OP_JMP);
        d_src1 = d_alu || (op_d == OP_LDR) ||
                 (op_d == OP_STR) || (op_d == OP_JMP);
        d_src2 = ((op_d == OP_ADD) || (op_d == OP_AND)) && !bus.IR[5];
        fwd_1  = x_alu && d_src1 &&
                 (bus.IR_Exec[11:9] == bus.IR[8:6]);
        fwd_2  = x_alu && d_src2 &&
                 (bus.IR_Exec[11:9] == bus.IR[2:0]);
    end

    always_comb begin
        state_d              = state_q;
        bus.enable_updatePC  = 1'b0;
        bus.enable_fetch     = 1'b0;
        bus.enable_decode    = 1'b0;
        bus.enable_execute   = 1'b0;
        bus.enable_writeback = 1'b0;
        bus.bypass_alu_1     = 1'b0;
        bus.bypass_alu_2     = 1'b0;
        bus.mem_state        = MS_IDLE;
        bus.br_taken         = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                bus.bypass_alu_1 = fwd_1;
                bus.bypass_alu_2 = fwd_2;
                if (bus.complete_instr) begin
                    bus.enable_updatePC  = 1'b1;
                    bus.enable_fetch     = 1'b1;
                    bus.enable_decode    = 1'b1;
                    bus.enable_execute   = 1'b1;
                    bus.enable_writeback = 1'b1;
                    // Memory op in execute wins; a held BR is seen again later.
                    if (x_mem)
                        state_d = x_ind ? S_MEM_IND : S_MEM_ACC;
                    else if (d_ctl)
                        state_d = S_BR_WAIT;
                end
            end
            S_MEM_IND: begin
                bus.mem_state = MS_IND;
                if (bus.complete_data)
                    state_d = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                bus.mem_state        = x_load ? MS_READ : MS_WRITE;
                bus.enable_writeback = x_load && bus.complete_data;
                if (bus.complete_data)
                    state_d = S_RUN;
            end
            S_BR_WAIT: begin
                bus.enable_decode    = 1'b1;
                bus.enable_execute   = 1'b1;
                bus.enable_writeback = 1'b1;
                state_d              = S_BR_RES;
            end
            S_BR_RES: begin
                bus.enable_updatePC = 1'b1;
                bus.br_taken = x_jmp ||
                               (|(bus.IR_Exec[11:9] & bus.psr));
                state_d      = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end
endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed self-checking bench for lc3_pipe_controller.
// Outputs packed as {updPC,fetch,dec,exe,wb,byp1,byp2,mem_state[1:0],br}.
module tb_lc3_pipe_controller;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    lc3_pipe_controller_if bus ();

    lc3_pipe_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] ire;
        logic [2:0]  psr;
        logic        ci;
        logic        cd;
        logic [9:0]  exp;
        string       name;
    } vec_t;

    localparam logic [9:0] E_RUN  = 10'b11111_00_11_0;
    localparam logic [9:0] E_OFF  = 10'b00000_00_11_0;
    localparam logic [9:0] E_BRW  = 10'b00111_00_11_0;
    localparam logic [9:0] E_BRT  = 10'b10000_00_11_1;
    localparam logic [9:0] E_BRN  = 10'b10000_00_11_0;
    localparam logic [9:0] E_IND  = 10'b00000_00_01_0;
    localparam logic [9:0] E_RD   = 10'b00000_00_00_0;
    localparam logic [9:0] E_RDWB = 10'b00001_00_00_0;
    localparam logic [9:0] E_WR   = 10'b00000_00_10_0;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [15:0] ir, input logic [15:0] ire,
                                input logic [2:0] psr, input logic ci,
                                input logic cd, input logic [9:0] exp,
                                input string name);
        vec_t v;
        v.ir = ir; v.ire = ire; v.psr = psr;
        v.ci = ci; v.cd = cd; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                bus.enable_execute, bus.enable_writeback,
                bus.bypass_alu_1, bus.bypass_alu_2, bus.mem_state,
                bus.br_taken};
    endfunction

    task automatic check(input logic [9:0] exp, input string name);
        logic [9:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ir, input logic [15:0] ire,
                         input logic [2:0] psr, input logic ci, input logic cd);
        bus.IR             = ir;
        bus.IR_Exec        = ire;
        bus.psr            = psr;
        bus.complete_instr = ci;
        bus.complete_data  = cd;
        bus.NZP            = 3'b000;
    endtask

    // Called just after a falling edge; checks mid-cycle, then advances one clock.
    task automatic step(input vec_t v);
        drive(v.ir, v.ire, v.psr, v.ci, v.cd);
        #2;
        check(v.exp, v.name);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(16'h1020, 16'hE000, 3'b000, 1'b1, 1'b0);

        // Forwarding, stall-hold and branch resolution
        tbl[0]  = mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "run_quiet");
        tbl[1]  = mk(16'h0405, 16'hE000, 3'b010, 0, 0, E_OFF, "run_no_instr");
        tbl[2]  = mk(16'h18C3, 16'h1642, 3'b000, 1, 0,
                     10'b11111_11_11_0, "fwd_add_both");
        tbl[3]  = mk(16'h18E3, 16'h5642, 3'b000, 1, 0,
                     10'b11111_10_11_0, "fwd_and_imm");
        tbl[4]  = mk(16'h18C3, 16'hE600, 3'b000, 1, 0, E_RUN, "fwd_lea_none");
        tbl[5]  = mk(16'h66C0, 16'h1642, 3'b000, 1, 0,
                     10'b11111_10_11_0, "fwd_ldr_base");
        tbl[6]  = mk(16'h26C0, 16'h1642, 3'b000, 1, 0, E_RUN, "fwd_ld_none");
        tbl[7]  = mk(16'h0405, 16'hE000, 3'b010, 1, 0, E_RUN, "brz_detect");
        tbl[8]  = mk(16'h1020, 16'h0405, 3'b010, 1, 0, E_BRW, "brz_wait");
        tbl[9]  = mk(16'h1020, 16'h0405, 3'b010, 1, 0, E_BRT, "brz_taken");
        tbl[10] = mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "run_after_br");
        tbl[11] = mk(16'h0405, 16'hE000, 3'b001, 1, 0, E_RUN, "brz2_detect");
        tbl[12] = mk(16'h18C3, 16'h1642, 3'b001, 1, 0, E_BRW, "brz2_wait_nofwd");
        tbl[13] = mk(16'h1020, 16'h0405, 3'b001, 1, 0, E_BRN, "brz2_not_taken");
        tbl[14] = mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "run_after_br2");

        @(negedge clock);
        #2;
        check(E_OFF, "reset_outputs");
        @(negedge clock);
        reset = 1'b0;
        #2;
        check(E_OFF, "idle_after_release");
        @(posedge clock);
        @(negedge clock);

        foreach (tbl[i]) step(tbl[i]);

        // LDI with two wait cycles on the indirect read
        step(mk(16'h1020, 16'hA200, 3'b000, 1, 0, E_RUN, "ldi_detect"));
        step(mk(16'h1020, 16'hA200, 3'b000, 1, 0, E_IND, "ldi_ind_w1"));
        step(mk(16'h1020, 16'hA200, 3'b000, 1, 0, E_IND, "ldi_ind_w2"));
        step(mk(16'h1020, 16'hA200, 3'b000, 1, 1, E_IND, "ldi_ind_done"));
        step(mk(16'h1020, 16'hA200, 3'b000, 1, 0, E_RD, "ldi_acc_wait"));
        step(mk(16'h1020, 16'hA200, 3'b000, 1, 1, E_RDWB, "ldi_acc_done"));
        step(mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "ldi_back_run"));

        // STR: write, never writeback
        step(mk(16'h1020, 16'h7242, 3'b000, 1, 0, E_RUN, "str_detect"));
        step(mk(16'h1020, 16'h7242, 3'b000, 1, 0, E_WR, "str_wait"));
        step(mk(16'h1020, 16'h7242, 3'b000, 1, 1, E_WR, "str_done"));
        step(mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "str_back_run"));

        // LD in execute collides with JMP in decode
        step(mk(16'hC1C0, 16'h2202, 3'b000, 1, 0, E_RUN, "col_detect"));
        step(mk(16'hC1C0, 16'h2202, 3'b000, 1, 1, E_RDWB, "col_mem_first"));
        step(mk(16'hC1C0, 16'hE000, 3'b000, 1, 0, E_RUN, "col_run_jmp"));
        step(mk(16'h1020, 16'hC1C0, 3'b000, 1, 0, E_BRW, "col_br_wait"));
        step(mk(16'h1020, 16'hC1C0, 3'b000, 1, 0, E_BRT, "col_jmp_taken"));
        step(mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "col_back_run"));

        // Async reset in the middle of a stalled data access
        step(mk(16'h1020, 16'h2202, 3'b000, 1, 0, E_RUN, "rst_ld_detect"));
        drive(16'h1020, 16'h2202, 3'b000, 1'b1, 1'b0);
        #1;
        check(E_RD, "rst_mem_acc");
        #1;
        reset = 1'b1;
        #1;
        check(E_OFF, "rst_async_idle");
        @(negedge clock);
        reset = 1'b0;
        drive(16'h1020, 16'hE000, 3'b000, 1'b1, 1'b0);
        #2;
        check(E_OFF, "rst_released_idle");
        @(posedge clock);
        @(negedge clock);
        step(mk(16'h1020, 16'hE000, 3'b000, 1, 0, E_RUN, "rst_run_again"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
